// File: rtl/upower_multicycle_ctrl_if.sv
// Control-side bundle between the uPower multicycle controller and its datapath/memory port.
// Memory handshake: mem_req is held high until a cycle where mem_ack is also high; that cycle completes the request.
interface upower_multicycle_ctrl_if;
    logic       run;
    logic [5:0] po;
    logic [1:0] xods;
    logic       lk;
    logic       cond_true;
    logic       mem_ack;
    logic [2:0] state;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_write;
    logic       alu_src_imm;
    logic [1:0] alu_sel;
    logic       reg_write;
    logic       rf_wsel;
    logic       lr_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       retired;
    logic       illegal;

    modport master (
        input  run, po, xods, lk, cond_true, mem_ack,
        output state, mem_req, mem_we, mem_addr_sel, ir_write, alu_src_imm, alu_sel,
               reg_write, rf_wsel, lr_write, pc_write, pc_src, retired, illegal
    );

    modport slave (
        output run, po, xods, lk, cond_true, mem_ack,
        input  state, mem_req, mem_we, mem_addr_sel, ir_write, alu_src_imm, alu_sel,
               reg_write, rf_wsel, lr_write, pc_write, pc_src, retired, illegal
    );
endinterface

// File: rtl/upower_multicycle_ctrl.sv
// Multi-cycle fetch/decode/exec/mem/writeback sequencer for the uPower core over a shared memory port.
// The instruction class is latched in DECODE so every later-stage output is decoded from state plus that class.
module upower_multicycle_ctrl (
    input  logic                            clk,
    input  logic                            rst,
    upower_multicycle_ctrl_if.master        bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_ALUR, C_ADDI, C_LOGI, C_LOAD, C_STORE, C_BC, C_B, C_ILL
    } cls_t;

    function automatic cls_t classify(input logic [5:0] po, input logic [1:0] xods);
        cls_t c;
        case (po)
            6'd31:                      c = C_ALUR;
            6'd14, 6'd15:               c = C_ADDI;
            6'd24, 6'd26, 6'd28:        c = C_LOGI;
            6'd32, 6'd34, 6'd40, 6'd42: c = C_LOAD;
            6'd58:                      c = (xods == 2'd0) ? C_LOAD : C_ILL;
            6'd36, 6'd37, 6'd38, 6'd44: c = C_STORE;
            6'd62:                      c = (xods == 2'd0) ? C_STORE : C_ILL;
            6'd19:                      c = C_BC;
            6'd18:                      c = C_B;
            default:                    c = C_ILL;
        endcase
        return c;
    endfunction

    state_t state_q, state_d;
    cls_t   cls_q, dec_cls;
    logic   pending_q;
    logic   illegal_q;

    logic       mem_req, mem_we, mem_addr_sel, ir_write, alu_src_imm;
    logic [1:0] alu_sel, pc_src;
    logic       reg_write, rf_wsel, lr_write, pc_write, retired;
    logic       ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            cls_q     <= C_ILL;
            pending_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            if (state_q == S_DECODE) cls_q <= dec_cls;
            // Once a fetch request is out, run no longer matters until it is acknowledged.
            pending_q <= (state_q == S_FETCH) && mem_req && !bus.mem_ack;
            if (state_d == S_HALT) illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        alu_src_imm  = 1'b0;
        alu_sel      = 2'd0;
        reg_write    = 1'b0;
        rf_wsel      = 1'b0;
        lr_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'd0;
        retired      = 1'b0;
        dec_cls      = classify(bus.po, bus.xods);
        // A reset edge in progress swallows any acknowledge so nothing retires on it.
        ack          = bus.mem_ack && !rst;

        // ALU selects stay constant from EXEC through WB for combinational recompute.
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            case (cls_q)
                C_ALUR:          alu_sel = 2'd1;
                C_ADDI:          alu_src_imm = 1'b1;
                C_LOGI: begin
                    alu_src_imm = 1'b1;
                    alu_sel     = 2'd2;
                end
                C_LOAD, C_STORE: alu_src_imm = 1'b1;
                default: ;
            endcase
        end

        case (state_q)
            S_FETCH: begin
                mem_req = (bus.run || pending_q) && !rst;
                if (mem_req && ack) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = (dec_cls == C_ILL) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                case (cls_q)
                    C_LOAD, C_STORE: state_d = S_MEM;
                    C_BC: begin
                        pc_write = 1'b1;
                        pc_src   = bus.cond_true ? 2'd1 : 2'd0;
                        lr_write = bus.lk;
                        retired  = 1'b1;
                        state_d  = S_FETCH;
                    end
                    C_B: begin
                        pc_write = 1'b1;
                        pc_src   = 2'd2;
                        lr_write = bus.lk;
                        retired  = 1'b1;
                        state_d  = S_FETCH;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (cls_q == C_STORE);
                if (ack) begin
                    if (cls_q == C_STORE) begin
                        pc_write = 1'b1;
                        retired  = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d  = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                rf_wsel   = (cls_q == C_LOAD);
                pc_write  = 1'b1;
                retired   = 1'b1;
                state_d   = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    assign bus.state        = state_q;
    assign bus.mem_req      = mem_req;
    assign bus.mem_we       = mem_we;
    assign bus.mem_addr_sel = mem_addr_sel;
    assign bus.ir_write     = ir_write;
    assign bus.alu_src_imm  = alu_src_imm;
    assign bus.alu_sel      = alu_sel;
    assign bus.reg_write    = reg_write;
    assign bus.rf_wsel      = rf_wsel;
    assign bus.lr_write     = lr_write;
    assign bus.pc_write     = pc_write;
    assign bus.pc_src       = pc_src;
    assign bus.retired      = retired;
    assign bus.illegal      = illegal_q;

endmodule

// File: tb/tb_upower_multicycle_ctrl.sv
// Bench for upower_multicycle_ctrl: builds the expected per-cycle output trace of each instruction
// from its class and acknowledge timing, and checks the controller cycle by cycle.
module tb_upower_multicycle_ctrl;
    localparam int W = 18;
    localparam int K_ALUR = 0, K_ADDI = 1, K_LOGI = 2, K_LOAD = 3, K_STORE = 4, K_BC = 5, K_B = 6, K_ILL = 7;
    localparam int P_FETCH = 0, P_DECODE = 1, P_EXEC = 2, P_MEM = 3, P_WB = 4, P_HALT = 5;

    typedef struct packed {
        logic [2:0] state;
        logic       mem_req, mem_we, mem_addr_sel, ir_write, alu_src_imm;
        logic [1:0] alu_sel;
        logic       reg_write, rf_wsel, lr_write, pc_write;
        logic [1:0] pc_src;
        logic       retired, illegal;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    upower_multicycle_ctrl_if bus();
    upower_multicycle_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    // clock / reset block
    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    int total = 0, bad = 0;
    int cyc_n = 0, t_req = 0, last_lat = -1;
    bit req_seen = 0;
    int cur_po = 0, cur_xods = 0;
    bit cur_lk = 0, cur_rst = 1;

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic int classify_b(int po, int xods);
        if (po == 31) return K_ALUR;
        if (po inside {14, 15}) return K_ADDI;
        if (po inside {24, 26, 28}) return K_LOGI;
        if (po inside {32, 34, 40, 42} || (po == 58 && xods == 0)) return K_LOAD;
        if (po inside {36, 37, 38, 44} || (po == 62 && xods == 0)) return K_STORE;
        if (po == 19) return K_BC;
        if (po == 18) return K_B;
        return K_ILL;
    endfunction

    // Expected outputs for one cycle spent in phase ph on an instruction of class k.
    function automatic logic [W-1:0] model(int ph, int k, bit req, bit ack, bit cond, bit lk);
        out_t o;
        o = '0;
        o.state = 3'(ph);
        if (ph == P_EXEC || ph == P_MEM || ph == P_WB) begin
            if (k == K_ALUR) o.alu_sel = 2'd1;
            if (k == K_ADDI || k == K_LOAD || k == K_STORE) o.alu_src_imm = 1'b1;
            if (k == K_LOGI) begin o.alu_src_imm = 1'b1; o.alu_sel = 2'd2; end
        end
        if (ph == P_FETCH) begin
            o.mem_req  = req;
            o.ir_write = req && ack;
        end
        if (ph == P_EXEC && (k == K_BC || k == K_B)) begin
            o.pc_write = 1'b1;
            o.retired  = 1'b1;
            o.lr_write = lk;
            o.pc_src   = (k == K_B) ? 2'd2 : (cond ? 2'd1 : 2'd0);
        end
        if (ph == P_MEM) begin
            o.mem_req      = 1'b1;
            o.mem_addr_sel = 1'b1;
            o.mem_we       = (k == K_STORE);
            if (ack && k == K_STORE) begin o.pc_write = 1'b1; o.retired = 1'b1; end
        end
        if (ph == P_WB) begin
            o.reg_write = 1'b1;
            o.rf_wsel   = (k == K_LOAD);
            o.pc_write  = 1'b1;
            o.retired   = 1'b1;
        end
        if (ph == P_HALT) o.illegal = 1'b1;
        return o;
    endfunction

    function automatic logic [W-1:0] dut_out();
        out_t o;
        o.state = bus.state; o.mem_req = bus.mem_req; o.mem_we = bus.mem_we;
        o.mem_addr_sel = bus.mem_addr_sel; o.ir_write = bus.ir_write;
        o.alu_src_imm = bus.alu_src_imm; o.alu_sel = bus.alu_sel;
        o.reg_write = bus.reg_write; o.rf_wsel = bus.rf_wsel; o.lr_write = bus.lr_write;
        o.pc_write = bus.pc_write; o.pc_src = bus.pc_src; o.retired = bus.retired;
        o.illegal = bus.illegal;
        return o;
    endfunction

    // scoreboard: one compare per driven cycle, plus fetch-to-retire latency measurement
    always @(negedge clk) begin
        logic [W-1:0] e, a;
        cyc_n++;
        if (rst) req_seen = 0;
        else begin
            if (bus.state == 3'd0 && bus.mem_req && !req_seen) begin t_req = cyc_n; req_seen = 1; end
            if (bus.retired) begin last_lat = cyc_n - t_req + 1; req_seen = 0; end
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = dut_out();
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL trace cyc=%0d po=%0d got=%05h exp=%05h", cyc_n, cur_po, a, e);
            end
        end
    end

    // driver tasks
    task automatic cyc(bit r, bit a, bit c, logic [W-1:0] e);
        @(posedge clk); #1;
        rst = cur_rst;
        bus.run = r; bus.mem_ack = a; bus.cond_true = c;
        bus.po = 6'(cur_po); bus.xods = 2'(cur_xods); bus.lk = cur_lk;
        exp_q.push_back(e);
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    task automatic pin(string name, int got, int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic do_reset(int n);
        cur_rst = 1;
        @(posedge clk); #1;
        rst = 1'b1; bus.run = 1'b1; bus.mem_ack = rb();
        for (int i = 1; i < n; i++) cyc(1'b1, rb(), rb(), model(P_FETCH, K_ILL, 0, 0, 0, 0));
        cur_rst = 0;
        settle();
        pin("reset_state", int'(bus.state), 0);
        pin("reset_illegal", int'(bus.illegal), 0);
        pin("reset_mem_req", int'(bus.mem_req), 0);
    endtask

    task automatic do_instr(int po, int xods, bit lk, bit cond, int fw, int mw, bit run_rest);
        int k;
        bit c, a;
        k = classify_b(po, xods);
        cur_po = po; cur_xods = xods; cur_lk = lk;
        last_lat = -1;
        for (int i = 0; i <= fw; i++) begin
            a = (i == fw);
            cyc((i == 0) ? 1'b1 : run_rest, a, rb(), model(P_FETCH, k, 1, a, 0, lk));
        end
        cyc(run_rest, rb(), rb(), model(P_DECODE, k, 0, 0, 0, lk));
        if (k != K_ILL) begin
            c = (k == K_BC) ? cond : rb();
            cyc(run_rest, rb(), c, model(P_EXEC, k, 0, 0, c, lk));
            if (k == K_LOAD || k == K_STORE)
                for (int j = 0; j <= mw; j++) begin
                    a = (j == mw);
                    cyc(run_rest, a, rb(), model(P_MEM, k, 1, a, 0, lk));
                end
            if (k == K_ALUR || k == K_ADDI || k == K_LOGI || k == K_LOAD)
                cyc(run_rest, rb(), rb(), model(P_WB, k, 0, 0, 0, lk));
        end
        settle();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(1'b0, rb(), rb(), model(P_FETCH, K_ILL, 0, 0, 0, 0));
        settle();
    endtask

    task automatic halt_cycles(int n);
        for (int i = 0; i < n; i++) cyc(1'b1, rb(), rb(), model(P_HALT, K_ILL, 0, 0, 0, 0));
        settle();
    endtask

    task automatic rst_in_mem_store();
        bit lk;
        lk = rb();
        cur_po = 38; cur_xods = 0; cur_lk = lk;
        cyc(1'b1, 1'b1, rb(), model(P_FETCH, K_STORE, 1, 1, 0, lk));
        cyc(1'b1, rb(), rb(), model(P_DECODE, K_STORE, 0, 0, 0, lk));
        cyc(1'b1, rb(), rb(), model(P_EXEC, K_STORE, 0, 0, 0, lk));
        cur_rst = 1;
        cyc(1'b1, 1'b1, rb(), model(P_MEM, K_STORE, 1, 0, 0, lk));
        cur_rst = 0;
        cyc(1'b0, 1'b1, rb(), model(P_FETCH, K_STORE, 0, 1, 0, lk));
        settle();
    endtask

    initial begin
        bus.run = 1'b0; bus.po = '0; bus.xods = '0; bus.lk = 1'b0;
        bus.cond_true = 1'b0; bus.mem_ack = 1'b0;

        do_reset(3);
        do_instr(31, 0, 1'b0, 1'b0, 0, 0, 1'b1); pin("lat_add", last_lat, 4);
        do_instr(14, 0, 1'b1, 1'b0, 0, 0, 1'b1); pin("lat_addi", last_lat, 4);
        do_instr(24, 0, 1'b0, 1'b0, 0, 0, 1'b1); pin("lat_ori", last_lat, 4);
        do_instr(32, 0, 1'b0, 1'b0, 0, 2, 1'b1); pin("lat_lwz_wait2", last_lat, 7);
        do_instr(58, 0, 1'b1, 1'b0, 0, 0, 1'b1); pin("lat_ld", last_lat, 5);
        do_instr(62, 0, 1'b0, 1'b0, 0, 0, 1'b1); pin("lat_std", last_lat, 4);
        do_instr(19, 0, 1'b1, 1'b1, 0, 0, 1'b1); pin("lat_bc_taken", last_lat, 3);
        do_instr(19, 0, 1'b1, 1'b0, 0, 0, 1'b1); pin("lat_bc_not", last_lat, 3);
        do_instr(18, 0, 1'b0, 1'b0, 0, 0, 1'b1); pin("lat_b", last_lat, 3);
        do_instr(28, 0, 1'b0, 1'b0, 2, 0, 1'b0); pin("lat_andi_fwait2", last_lat, 6);
        idle(3);
        do_instr(40, 0, 1'b0, 1'b0, 1, 1, 1'b1); pin("lat_lhz_waits", last_lat, 7);

        do_reset(2);
        idle(5);
        do_instr(36, 0, 1'b0, 1'b0, 0, 0, 1'b0); pin("lat_stw_rundrop", last_lat, 4);
        idle(4);

        do_instr(62, 1, 1'b0, 1'b0, 0, 0, 1'b1);
        halt_cycles(20);
        pin("halt_illegal", int'(bus.illegal), 1);
        do_reset(2);
        do_instr(7, 0, 1'b0, 1'b0, 0, 0, 1'b1);
        halt_cycles(20);
        do_reset(2);

        do_instr(15, 0, 1'b0, 1'b0, 0, 0, 1'b1);
        rst_in_mem_store();
        do_instr(31, 0, 1'b0, 1'b0, 0, 0, 1'b1); pin("lat_add_after_rst", last_lat, 4);
        idle(2);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
